// File: rtl/uart_apb_fifo_if.sv
`timescale 1ns/1ps
// APB3 bus bundle between an SoC master and the uart_apb_fifo peripheral.
interface uart_apb_fifo_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_apb_fifo.sv
`timescale 1ns/1ps
// APB UART with programmable divisor, optional parity and TX/RX FIFOs.
// Registers: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DIV.

module uart_apb_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [W-1:0] mem [DEPTH];
  ptr_t         wr_ptr_reg, rd_ptr_reg;
  logic         do_push, do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (count == '0);
  assign full    = (count == ptr_t'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
    end
  end
endmodule

module uart_apb_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  uart_apb_fifo_if.slave     apb,
  input  logic               RX,
  output logic               TX,
  output logic               irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_BITS);
  typedef logic [DIV_W-1:0] div_t;
  typedef logic [BW-1:0]    bit_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Register file
  logic [5:0] ctrl_reg;
  div_t       div_reg;
  logic       tx_flush_reg, rx_flush_reg;
  logic       overrun_reg, frame_err_reg, parity_err_reg, irq_reg;

  // FIFO interfaces
  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic [CW-1:0]        tx_count, rx_count;
  logic                 tx_empty, tx_full, rx_empty, rx_full;
  logic                 tx_push, tx_pop, rx_pop;

  // TX engine
  state_t               tx_state_reg;
  div_t                 tx_cnt_reg, tx_div_reg;
  bit_t                 tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg, tx_pen_reg, tx_reg;
  logic                 tx_bit_end, tx_start, tx_busy;

  // RX engine
  logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
  state_t               rx_state_reg;
  div_t                 rx_cnt_reg, rx_div_reg;
  bit_t                 rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_pen_reg, rx_podd_reg;
  logic                 rx_push_reg, rx_fe_reg, rx_pe_reg;
  logic                 rx_bit_end, overrun_set;

  wire       tx_en      = ctrl_reg[0];
  wire       rx_en      = ctrl_reg[1];
  wire       parity_en  = ctrl_reg[2];
  wire       parity_odd = ctrl_reg[3];
  wire       irq_rx_en  = ctrl_reg[4];
  wire       irq_tx_en  = ctrl_reg[5];

  wire       access  = apb.PSEL & apb.PENABLE;
  wire [1:0] addr    = apb.PADDR[3:2];
  wire       data_wr = access &  apb.PWRITE & (addr == 2'd0);
  wire       data_rd = access & ~apb.PWRITE & (addr == 2'd0);
  div_t      div_wdata;
  logic      unused_apb;

  assign div_wdata   = apb.PWDATA[DIV_W-1:0];
  assign unused_apb  = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA};
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access && (addr == 2'd0) && (apb.PWRITE ? tx_full : rx_empty);
  assign tx_push     = data_wr & ~tx_full;
  assign rx_pop      = data_rd & ~rx_empty;
  assign tx_busy     = (tx_state_reg != S_IDLE);
  assign overrun_set = rx_push_reg & rx_full & ~rx_pop;
  assign TX          = tx_reg;
  assign irq         = irq_reg;

  always_comb begin
    apb.PRDATA = '0;
    if (access && !apb.PWRITE) begin
      case (addr)
        2'd0: if (!rx_empty) apb.PRDATA[DATA_BITS-1:0] = rx_head;
        2'd1: apb.PRDATA = {16'h0, 8'(rx_count), parity_err_reg, frame_err_reg, overrun_reg,
                            tx_busy, rx_full, rx_empty, tx_full, tx_empty};
        2'd2: apb.PRDATA = {26'h0, ctrl_reg};
        default: apb.PRDATA = 32'(div_reg);
      endcase
    end
  end

  uart_apb_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(PCLK), .rst_n(PRESETn), .flush(tx_flush_reg), .push(tx_push), .push_data(apb.PWDATA[DATA_BITS-1:0]),
    .pop(tx_pop), .head(tx_head), .count(tx_count), .empty(tx_empty), .full(tx_full));

  uart_apb_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(PCLK), .rst_n(PRESETn), .flush(rx_flush_reg), .push(rx_push_reg), .push_data(rx_shift_reg),
    .pop(rx_pop), .head(rx_head), .count(rx_count), .empty(rx_empty), .full(rx_full));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_reg       <= '0;
      div_reg        <= div_t'(DEFAULT_DIV);
      tx_flush_reg   <= 1'b0;
      rx_flush_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      tx_flush_reg   <= 1'b0;
      rx_flush_reg   <= 1'b0;
      // Hardware set wins over a simultaneous write-1-to-clear.
      overrun_reg    <= (overrun_reg    & ~(access & apb.PWRITE & (addr == 2'd1) & apb.PWDATA[5])) | overrun_set;
      frame_err_reg  <= (frame_err_reg  & ~(access & apb.PWRITE & (addr == 2'd1) & apb.PWDATA[6]))
                        | (rx_push_reg & rx_fe_reg);
      parity_err_reg <= (parity_err_reg & ~(access & apb.PWRITE & (addr == 2'd1) & apb.PWDATA[7])) | rx_pe_reg;
      if (access && apb.PWRITE && addr == 2'd2) begin
        ctrl_reg     <= apb.PWDATA[5:0];
        tx_flush_reg <= apb.PWDATA[6];
        rx_flush_reg <= apb.PWDATA[7];
      end
      if (access && apb.PWRITE && addr == 2'd3)
        div_reg <= (div_wdata < div_t'(4)) ? div_t'(4) : div_wdata;
      irq_reg <= (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty)
                 | overrun_reg | frame_err_reg | parity_err_reg;
    end
  end

  assign tx_bit_end = (tx_cnt_reg == tx_div_reg - div_t'(1));
  // A new frame may begin from IDLE or straight out of the last STOP cycle.
  assign tx_start   = tx_en && !tx_empty &&
                      ((tx_state_reg == S_IDLE) || (tx_state_reg == S_STOP && tx_bit_end));
  assign tx_pop     = tx_start;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= div_t'(4);
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_pen_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else if (tx_start) begin
      tx_state_reg <= S_START;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= div_reg;
      tx_bit_reg   <= '0;
      tx_shift_reg <= tx_head;
      tx_par_reg   <= parity_odd ? ~^tx_head : ^tx_head;
      tx_pen_reg   <= parity_en;
      tx_reg       <= 1'b0;
    end else begin
      tx_cnt_reg <= tx_bit_end ? '0 : tx_cnt_reg + div_t'(1);
      case (tx_state_reg)
        S_IDLE: begin
          tx_cnt_reg <= '0;
          tx_reg     <= 1'b1;
        end
        S_START: if (tx_bit_end) begin
          tx_state_reg <= S_DATA;
          tx_reg       <= tx_shift_reg[0];
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_bit_reg == bit_t'(DATA_BITS - 1)) begin
            tx_state_reg <= tx_pen_reg ? S_PARITY : S_STOP;
            tx_reg       <= tx_pen_reg ? tx_par_reg : 1'b1;
          end else begin
            tx_bit_reg   <= tx_bit_reg + bit_t'(1);
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_reg       <= tx_shift_reg[1];
          end
        end
        S_PARITY: if (tx_bit_end) begin
          tx_state_reg <= S_STOP;
          tx_reg       <= 1'b1;
        end
        S_STOP: if (tx_bit_end) tx_state_reg <= S_IDLE;
        default: tx_state_reg <= S_IDLE;
      endcase
    end
  end

  assign rx_bit_end = (rx_cnt_reg == rx_div_reg - div_t'(1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= S_IDLE;
      rx_cnt_reg   <= '0;
      rx_div_reg   <= div_t'(4);
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_pen_reg   <= 1'b0;
      rx_podd_reg  <= 1'b0;
      rx_push_reg  <= 1'b0;
      rx_fe_reg    <= 1'b0;
      rx_pe_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= RX;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      rx_push_reg <= 1'b0;
      rx_pe_reg   <= 1'b0;
      rx_cnt_reg  <= rx_bit_end ? '0 : rx_cnt_reg + div_t'(1);
      case (rx_state_reg)
        S_IDLE: begin
          rx_cnt_reg <= '0;
          if (rx_en && rx_prev_reg && !rx_sync_reg) begin
            rx_state_reg <= S_START;
            rx_div_reg   <= div_reg;
            rx_pen_reg   <= parity_en;
            rx_podd_reg  <= parity_odd;
          end
        end
        // Half a bit in: a high line here means the falling edge was a glitch.
        S_START: if (rx_cnt_reg == (rx_div_reg >> 1) - div_t'(1)) begin
          rx_cnt_reg   <= '0;
          rx_bit_reg   <= '0;
          rx_state_reg <= rx_sync_reg ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_bit_end) begin
          rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
          rx_bit_reg   <= rx_bit_reg + bit_t'(1);
          if (rx_bit_reg == bit_t'(DATA_BITS - 1))
            rx_state_reg <= rx_pen_reg ? S_PARITY : S_STOP;
        end
        S_PARITY: if (rx_bit_end) begin
          rx_pe_reg    <= rx_sync_reg != (rx_podd_reg ? ~^rx_shift_reg : ^rx_shift_reg);
          rx_state_reg <= S_STOP;
        end
        S_STOP: if (rx_bit_end) begin
          rx_push_reg  <= 1'b1;
          rx_fe_reg    <= ~rx_sync_reg;
          rx_state_reg <= S_IDLE;
        end
        default: rx_state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_apb_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_apb_fifo: APB reads and TX frames are checked by monitors.
module tb_uart_apb_fifo;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic TX, irq;
  wire  rx_line = loop_en ? TX : rx_drv;

  always #5 PCLK = ~PCLK;

  uart_apb_fifo_if apb();

  uart_apb_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(434)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb), .RX(rx_line), .TX(TX), .irq(irq));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc++;

  typedef struct { string name; logic [31:0] exp; logic [31:0] mask; logic err; bit chk; } apb_exp_t;
  typedef struct { string name; logic [10:0] bits; int gap; } tx_exp_t;
  apb_exp_t apb_q[$];
  tx_exp_t  tx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else
      $display("ok   %s: 0x%08h", name, act);
  endtask

  // APB monitor: every access phase pops one expectation.
  always @(negedge PCLK) begin
    apb_exp_t e;
    if (apb.PSEL && apb.PENABLE) begin
      if (apb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL apb_unexpected: got access addr=0x%08h expected none", apb.PADDR);
      end else begin
        e = apb_q.pop_front();
        if (e.chk) begin
          checks++;
          if (apb.PSLVERR !== e.err || (apb.PRDATA & e.mask) !== (e.exp & e.mask)) begin
            failures++;
            $display("FAIL %s: got data=0x%08h err=%0b expected data=0x%08h err=%0b",
                     e.name, apb.PRDATA, apb.PSLVERR, e.exp, e.err);
          end else
            $display("ok   %s: data=0x%08h err=%0b", e.name, apb.PRDATA, apb.PSLVERR);
        end else
          $display("apb  %s addr=0x%0h data=0x%08h", apb.PWRITE ? "wr" : "rd", apb.PADDR, apb.PWDATA);
      end
    end
  end

  // TX monitor (bit period 4): samples each bit mid-period once a frame is expected.
  initial begin
    logic prev;
    logic [10:0] got;
    int last_start;
    tx_exp_t e;
    prev = 1'b1;
    last_start = 0;
    forever begin
      @(negedge PCLK);
      if (tx_q.size() > 0 && prev === 1'b1 && TX === 1'b0) begin
        int start_cyc;
        start_cyc = cyc;
        repeat (2) @(negedge PCLK);
        got[0] = TX;
        for (int i = 1; i < 11; i++) begin
          repeat (4) @(negedge PCLK);
          got[i] = TX;
        end
        if (tx_q.size() > 0) begin
          e = tx_q.pop_front();
          chk(e.name, 32'(got), 32'(e.bits));
          if (e.gap > 0) chk({e.name, "_gap"}, 32'(start_cyc - last_start), 32'(e.gap));
        end
        last_start = start_cyc;
      end
      prev = TX;
    end
  end

  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = w; apb.PADDR = a; apb.PWDATA = d;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    apb_exp_t e;
    e.name = "wr"; e.exp = '0; e.mask = '0; e.err = 1'b0; e.chk = 1'b0;
    apb_q.push_back(e);
    apb_xfer(1'b1, a, d);
  endtask

  task automatic wr_e(input string name, input logic [31:0] a, input logic [31:0] d, input logic err);
    apb_exp_t e;
    e.name = name; e.exp = '0; e.mask = '0; e.err = err; e.chk = 1'b1;
    apb_q.push_back(e);
    apb_xfer(1'b1, a, d);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp, input logic err);
    apb_exp_t e;
    e.name = name; e.exp = exp; e.mask = 32'hFFFF_FFFF; e.err = err; e.chk = 1'b1;
    apb_q.push_back(e);
    apb_xfer(1'b0, a, 32'h0);
  endtask

  // Drive one serial frame at 8 clocks per bit, then one idle bit.
  task automatic send_rx(input logic [7:0] data, input bit pen, input logic pbit, input logic stopb);
    @(posedge PCLK); #1;
    rx_drv = 1'b0;
    repeat (8) @(posedge PCLK); #1;
    for (int i = 0; i < 8; i++) begin
      rx_drv = data[i];
      repeat (8) @(posedge PCLK); #1;
    end
    if (pen) begin
      rx_drv = pbit;
      repeat (8) @(posedge PCLK); #1;
    end
    rx_drv = stopb;
    repeat (8) @(posedge PCLK); #1;
    rx_drv = 1'b1;
    repeat (8) @(posedge PCLK); #1;
  endtask

  task automatic wait_tx_done(input int limit);
    int n;
    n = 0;
    while (tx_q.size() > 0 && n < limit) begin
      @(posedge PCLK);
      n++;
    end
    checks++;
    if (tx_q.size() > 0) begin
      failures++;
      $display("FAIL tx_frames_timeout: got %0d frames pending expected 0", tx_q.size());
      tx_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_exp_t f;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    repeat (3) @(posedge PCLK); #1;
    chk("rst_tx", 32'(TX), 32'h1);
    chk("rst_irq", 32'(irq), 32'h0);
    PRESETn = 1'b1;
    rd("rst_status", 32'h4, 32'h0000_0005, 1'b0);
    rd("rst_div", 32'hC, 32'd434, 1'b0);
    rd("rst_ctrl", 32'h8, 32'h0, 1'b0);

    // TX: DIV=4, odd parity, two back-to-back frames
    wr(32'hC, 32'd4);
    wr(32'h8, 32'h0C);
    f.name = "tx_frame_a5"; f.bits = 11'b1_1_10100101_0; f.gap = 0;  tx_q.push_back(f);
    f.name = "tx_frame_3c"; f.bits = 11'b1_1_00111100_0; f.gap = 44; tx_q.push_back(f);
    wr(32'h0, 32'hA5);
    wr(32'h0, 32'h3C);
    wr(32'h8, 32'h0D);
    repeat (55) @(posedge PCLK);
    rd("tx_status_busy", 32'h4, 32'h0000_0015, 1'b0);
    wait_tx_done(300);
    repeat (10) @(posedge PCLK);
    rd("tx_status_done", 32'h4, 32'h0000_0005, 1'b0);

    // Reset asserted in the middle of a start bit
    wr(32'hC, 32'd100);
    wr(32'h0, 32'h55);
    wr(32'h8, 32'h01);
    repeat (50) @(posedge PCLK); #2;
    chk("midframe_tx_low", 32'(TX), 32'h0);
    PRESETn = 1'b0;
    #1;
    chk("async_rst_tx", 32'(TX), 32'h1);
    repeat (2) @(posedge PCLK); #1;
    PRESETn = 1'b1;
    rd("rst2_status", 32'h4, 32'h0000_0005, 1'b0);
    rd("rst2_div", 32'hC, 32'd434, 1'b0);
    rd("rst2_ctrl", 32'h8, 32'h0, 1'b0);

    // Loopback of 16 bytes at DIV=8
    loop_en = 1'b1;
    wr(32'hC, 32'd8);
    for (int i = 0; i < 16; i++) wr(32'h0, 32'(i));
    wr(32'h8, 32'h03);
    repeat (1400) @(posedge PCLK);
    rd("loop_status_full", 32'h4, 32'h0000_1009, 1'b0);
    for (int i = 0; i < 16; i++) rd($sformatf("loop_data%0d", i), 32'h0, 32'(i), 1'b0);
    rd("loop_status_empty", 32'h4, 32'h0000_0005, 1'b0);
    #1 chk("loop_irq", 32'(irq), 32'h0);
    wr(32'h8, 32'h0);
    loop_en = 1'b0;

    // Overrun: 17 frames, no reads
    wr(32'h8, 32'h02);
    for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge PCLK);
    rd("ovr_status", 32'h4, 32'h0000_1029, 1'b0);
    chk("ovr_irq", 32'(irq), 32'h1);
    wr(32'h4, 32'h20);
    chk("ovr_irq_reg_lag", 32'(irq), 32'h1);
    @(posedge PCLK); #1;
    chk("ovr_irq_clear", 32'(irq), 32'h0);
    rd("ovr_status_clr", 32'h4, 32'h0000_1009, 1'b0);
    rd("ovr_first_data", 32'h0, 32'h40, 1'b0);
    wr(32'h8, 32'h82);
    rd("rx_flush_status", 32'h4, 32'h0000_0005, 1'b0);

    // Line errors with even parity
    wr(32'h8, 32'h06);
    send_rx(8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge PCLK);
    rd("frame_err_status", 32'h4, 32'h0000_0141, 1'b0);
    rd("frame_err_data", 32'h0, 32'h5A, 1'b0);
    wr(32'h4, 32'h40);
    send_rx(8'h33, 1'b1, 1'b1, 1'b1);
    repeat (5) @(posedge PCLK);
    rd("parity_err_status", 32'h4, 32'h0000_0181, 1'b0);
    rd("parity_err_data", 32'h0, 32'h33, 1'b0);
    wr(32'h4, 32'h80);
    @(posedge PCLK); #1 rx_drv = 1'b0;
    @(posedge PCLK); #1 rx_drv = 1'b1;
    repeat (40) @(posedge PCLK);
    rd("glitch_status", 32'h4, 32'h0000_0005, 1'b0);

    // APB error responses
    wr(32'h8, 32'h0);
    rd("rd_empty_err", 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 15; i++) wr(32'h0, 32'(i));
    wr_e("wr_16th_ok", 32'h0, 32'h0F, 1'b0);
    wr_e("wr_full_err", 32'h0, 32'h99, 1'b1);
    rd("tx_full_status", 32'h4, 32'h0000_0006, 1'b0);
    wr(32'h8, 32'h40);
    rd("tx_flush_status", 32'h4, 32'h0000_0005, 1'b0);
    wr(32'hC, 32'd2);
    rd("div_clamp", 32'hC, 32'd4, 1'b0);

    repeat (3) @(posedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_apb_fifo.md
Name: uart_apb_fifo

Overview:
Parametrised next-generation APB UART peripheral. It integrates a programmable baud divisor, TX/RX engines with configurable data width and optional parity, and TX/RX FIFOs of configurable depth behind a four-register APB slave. It replaces the fixed single-byte UART + fixed baud generator + APB slave trio at the SoC peripheral bus level.

Parameters:
DATA_BITS, 8, UART character width (5..9)
FIFO_DEPTH, 16, entries per TX and RX FIFO (power of 2, >=2)
DIV_W, 16, width of baud divisor register
DEFAULT_DIV, 434, reset value of divisor (PCLK cycles per bit)

Ports:
PCLK  in  1  system clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write, 0=read
PADDR  in  32  byte address; bits [3:2] decode, others ignored
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied 1 (zero wait states)
PSLVERR  out  1  error response in access phase
RX  in  1  serial input, asynchronous
TX  out  1  serial output, idle high
irq  out  1  level interrupt

Behaviour:
- Reset (async, PRESETn=0): TX=1, PRDATA=0, PSLVERR=0, irq=0, FIFOs empty, CTRL=0, DIV=DEFAULT_DIV, sticky flags 0, both engines IDLE. Reset mid-frame aborts immediately; TX high on same edge.
- APB: transfer completes when PSEL&PENABLE (PREADY=1). Writes take effect at that edge; PRDATA combinational on decoded address during access phase, 0 otherwise.
- 0x0 DATA: write pushes PWDATA[DATA_BITS-1:0] to TX FIFO; read returns RX FIFO head in [DATA_BITS-1:0] and pops. Write when TX full or read when RX empty -> PSLVERR=1, no state change, read data 0.
- 0x4 STATUS: [0] tx_empty [1] tx_full [2] rx_empty [3] rx_full [4] tx_busy [5] overrun [6] frame_err [7] parity_err [15:8] rx_count. Bits 5..7 sticky, write-1-to-clear; others RO.
- 0x8 CTRL: [0] tx_en [1] rx_en [2] parity_en [3] parity_odd [4] irq_rx_en [5] irq_tx_en [6] tx_flush [7] rx_flush. Flush bits self-clear, read as 0; flush empties FIFO next cycle (does not abort frame in flight).
- 0xC DIV: bit period in PCLK cycles; writes <4 clamp to 4. Change takes effect at next frame start.
- TX FSM: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP -> IDLE. Leaves IDLE when tx_en=1 and FIFO non-empty: pops head same cycle. Each state held DIV cycles; data LSB first; parity even (parity_odd=0) or odd over data bits. STOP with FIFO non-empty and tx_en -> START directly (back-to-back, no idle gap). tx_en cleared mid-frame: frame completes, then IDLE. tx_busy=1 outside IDLE.
- RX: RX through 2-flop synchroniser. IDLE: on synced falling edge and rx_en=1 -> START, wait DIV/2; if line high return IDLE (glitch), else sample every DIV cycles: DATA_BITS bits, parity if enabled, stop. Stop=0 sets frame_err, parity mismatch sets parity_err; character still pushed. RX FIFO full at push -> character dropped, overrun=1. Engine returns IDLE after stop sample (mid-stop).
- FIFOs: circular, pointers width log2(FIFO_DEPTH)+1; simultaneous push and pop when full or empty both legal (pop from full frees slot; push to empty then pop next cycle). Push into full impossible by rules above.
- irq = (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty) | overrun | frame_err | parity_err, registered (one cycle after cause).
- Unmapped address: none (two-bit decode covers all).

Test Plan:
- Reset values: assert PRESETn=0 mid-transmit -> TX=1, STATUS reads 0x0000_0005, DIV reads 434, CTRL 0.
- TX: DIV=4, parity_en=1 odd, write 0xA5 then 0x3C, tx_en=1 -> TX shows start,10100101 LSB-first,parity=1,stop, then immediately next frame; each bit 4 cycles; tx_empty=1 after second pop.
- Loopback TX->RX, DIV=8, 16 bytes 0x00..0x0F -> RX FIFO full (rx_count=16, rx_full=1), reads return 0x00..0x0F in order, no error flags.
- Overrun: 17 RX frames without reads -> 17th dropped, overrun=1, irq=1; write 0x20 to STATUS -> overrun=0, irq drops next cycle.
- Errors: inject stop bit=0 -> frame_err=1, byte still stored; inject wrong parity -> parity_err=1; 1-cycle low glitch on RX -> nothing received.
- APB errors: read DATA with RX empty -> PSLVERR=1, PRDATA=0; write DATA with TX full (tx_en=0, 17 writes) -> 17th PSLVERR=1, tx_count stays 16; DIV write 2 reads back 4.
